// File: rtl/ponte_pkg.sv
// Shared definitions for the dual-rail adder bridge: dual-rail codes,
// FSM state type, default parameters and the binary-to-dual-rail encoders.
package ponte_pkg;

    // Dual-rail pair {x[2i+1], x[2i]}
    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_ONE     = 2'b01;
    localparam logic [1:0] DR_ZERO    = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    localparam int TIMEOUT_DEF = 255;
    localparam int SYNC_DEF    = 2;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        NULL_WAIT,
        RESULT,
        ERROR
    } state_t;

    function automatic logic [1:0] enc_bit(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

    function automatic logic [7:0] enc_nib(input logic [3:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[2*i +: 2] = enc_bit(x[i]);
        return r;
    endfunction

endpackage

// File: rtl/detetor_completude.sv
// Synchronizes the 10 dual-rail result wires and flags completion.
// Ports: clk, rst_n; raw (async adder wires); sinc (synchronized copy);
// all_data / all_null (stable over two samples); illegal (any pair 11).
module detetor_completude
    import ponte_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw,
    output logic [9:0] sinc,
    output logic       all_data,
    output logic       all_null,
    output logic       illegal
);

    logic [9:0] chain [SYNC_STAGES];
    logic [9:0] prev;
    logic       any_null;
    logic       any_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                chain[i] <= '0;
            prev <= '0;
        end else begin
            chain[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++)
                chain[i] <= chain[i-1];
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sinc = chain[SYNC_STAGES-1];

    always_comb begin
        any_null = 1'b0;
        any_ill  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (sinc[2*i +: 2] == DR_NULL)
                any_null = 1'b1;
            if (sinc[2*i +: 2] == DR_ILLEGAL)
                any_ill = 1'b1;
        end
    end

    // Two identical consecutive samples guard against skewed wires
    // still settling through the synchronizer.
    assign all_data = !any_null && !any_ill && (sinc == prev);
    assign all_null = (sinc == '0) && (prev == '0);
    assign illegal  = any_ill;

endmodule

// File: rtl/ponte_somador_dr.sv
// Bridge between a binary valid/ready stream and a 4-bit dual-rail adder.
// Ports: in_* operand handshake; dr_a/dr_b/dr_cin drive the adder;
// dr_s/dr_cout async results; out_* result handshake; err sticky fault.
module ponte_somador_dr
    import ponte_pkg::*;
#(
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_cin,
    output logic [7:0] dr_a,
    output logic [7:0] dr_b,
    output logic [1:0] dr_cin,
    input  logic [7:0] dr_s,
    input  logic [1:0] dr_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_cout,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t      state;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        op_cin;
    logic [CW-1:0] cnt;
    logic [9:0]  sinc;
    logic        all_data;
    logic        all_null;
    logic        illegal;
    logic [3:0]  dec_sum;
    logic        dec_cout;

    detetor_completude #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     ({dr_cout, dr_s}),
        .sinc    (sinc),
        .all_data(all_data),
        .all_null(all_null),
        .illegal (illegal)
    );

    always_comb begin
        dec_sum = '0;
        for (int i = 0; i < 4; i++)
            dec_sum[i] = (sinc[2*i +: 2] == DR_ONE);
        dec_cout = (sinc[9:8] == DR_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            cnt       <= '0;
            dr_a      <= '0;
            dr_b      <= '0;
            dr_cin    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    dr_a   <= '0;
                    dr_b   <= '0;
                    dr_cin <= '0;
                    if (in_valid && in_ready) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        op_cin   <= in_cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= DATA;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DATA: begin
                    if (illegal || (!all_data && cnt == TMAX)) begin
                        state  <= ERROR;
                        err    <= 1'b1;
                        dr_a   <= '0;
                        dr_b   <= '0;
                        dr_cin <= '0;
                    end else if (all_data) begin
                        out_sum  <= dec_sum;
                        out_cout <= dec_cout;
                        cnt      <= '0;
                        dr_a     <= '0;
                        dr_b     <= '0;
                        dr_cin   <= '0;
                        state    <= NULL_WAIT;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        dr_a   <= enc_nib(op_a);
                        dr_b   <= enc_nib(op_b);
                        dr_cin <= enc_bit(op_cin);
                    end
                end
                NULL_WAIT: begin
                    if (illegal || (!all_null && cnt == TMAX)) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else if (all_null) begin
                        out_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERROR: begin
                    err       <= 1'b1;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    dr_a      <= '0;
                    dr_b      <= '0;
                    dr_cin    <= '0;
                end
                default: begin
                    state <= ERROR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ponte_somador_dr.sv
// Self-checking bench for ponte_somador_dr with a behavioural
// zero-delay dual-rail adder model (normal / never completes / illegal).
module tb_ponte_somador_dr;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_cin;
    logic [7:0] dr_a;
    logic [7:0] dr_b;
    logic [1:0] dr_cin;
    logic [7:0] dr_s;
    logic [1:0] dr_cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_cout;
    logic       err;

    // 0: normal adder, 1: never completes, 2: drives illegal pair
    logic [1:0] mode = 2'd0;
    logic [4:0] s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ponte_somador_dr #(
        .TIMEOUT(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .dr_a     (dr_a),
        .dr_b     (dr_b),
        .dr_cin   (dr_cin),
        .dr_s     (dr_s),
        .dr_cout  (dr_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .err      (err)
    );

    function automatic logic [7:0] enc4(input logic [3:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[2*i +: 2] = x[i] ? 2'b01 : 2'b10;
        return r;
    endfunction

    function automatic logic ok4(input logic [7:0] d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 4; i++)
            if (d[2*i +: 2] != 2'b01 && d[2*i +: 2] != 2'b10)
                r = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] val4(input logic [7:0] d);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = (d[2*i +: 2] == 2'b01);
        return r;
    endfunction

    // Zero-delay dual-rail adder: NULL in -> NULL out, DATA in -> DATA out
    always_comb begin
        s       = '0;
        dr_s    = '0;
        dr_cout = '0;
        if (mode != 2'd1 && ok4(dr_a) && ok4(dr_b) &&
            (dr_cin == 2'b01 || dr_cin == 2'b10)) begin
            s = 5'(val4(dr_a)) + 5'(val4(dr_b)) + 5'(dr_cin == 2'b01);
            dr_s    = enc4(s[3:0]);
            dr_cout = s[4] ? 2'b01 : 2'b10;
            if (mode == 2'd2)
                dr_s[1:0] = 2'b11;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", 32'(in_ready), 0);
        tick();
        check("rel_ready_high", 32'(in_ready), 1);
        check("rel_err", 32'(err), 0);
    endtask

    task automatic accept(input logic [3:0] a, input logic [3:0] b,
                          input logic c);
        check("acc_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        tick();
        in_valid = 1'b0;
        in_a     = 4'($urandom);
        in_b     = 4'($urandom);
        in_cin   = 1'($urandom);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic c, input int hold);
        logic [4:0] exp_s;
        int  k;
        bit  rdy_low;
        bit  nul_last;
        exp_s    = 5'(a) + 5'(b) + 5'(c);
        rdy_low  = 1'b1;
        nul_last = 1'b0;
        accept(a, b, c);
        k = 0;
        while (!out_valid && k < 20) begin
            if (in_ready)
                rdy_low = 1'b0;
            if (k == 1) begin
                check("dr_a", 32'(dr_a), 32'(enc4(a)));
                check("dr_b", 32'(dr_b), 32'(enc4(b)));
                check("dr_cin", 32'(dr_cin), c ? 32'd1 : 32'd2);
            end
            nul_last = (dr_a == 8'h00) && (dr_b == 8'h00) &&
                       (dr_cin == 2'b00);
            tick();
            k++;
        end
        check("latency", 32'(k), 9);
        check("sum", 32'(out_sum), 32'(exp_s[3:0]));
        check("cout", 32'(out_cout), 32'(exp_s[4]));
        check("busy_ready", 32'(rdy_low), 1);
        check("dr_null_before", 32'(nul_last), 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sum", 32'(out_sum), 32'(exp_s[3:0]));
            check("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 0);
        check("post_ready", 32'(in_ready), 1);
        check("post_sum", 32'(out_sum), 32'(exp_s[3:0]));
        check("post_cout", 32'(out_cout), 32'(exp_s[4]));
    endtask

    initial begin
        int  k;
        bit  flag;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        #3;
        check("rst_ready", 32'(in_ready), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_dr", 32'({dr_a, dr_b, dr_cin}), 0);
        check("rst_sum", 32'({out_cout, out_sum}), 0);
        do_reset();

        run_op(4'd3, 4'd4, 1'b0, 0);
        run_op(4'd15, 4'd1, 1'b1, 0);
        run_op(4'd15, 4'd15, 1'b1, 10);
        run_op(4'd0, 4'd0, 1'b0, 0);
        for (int i = 0; i < 8; i++)
            run_op(4'($urandom), 4'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));

        // Adder never completes
        mode = 2'd1;
        accept(4'd5, 4'd6, 1'b0);
        k    = 0;
        flag = 1'b1;
        while (!err && k < 300) begin
            if (in_ready || out_valid)
                flag = 1'b0;
            tick();
            k++;
        end
        check("to_cycles", 32'(k), TO + 1);
        check("to_err", 32'(err), 1);
        check("to_quiet", 32'(flag), 1);
        repeat (5) tick();
        check("to_sticky", 32'(err), 1);
        check("to_ready", 32'(in_ready), 0);
        check("to_dr", 32'({dr_a, dr_b, dr_cin}), 0);
        mode = 2'd0;
        do_reset();

        // Illegal pair from the adder
        mode = 2'd2;
        accept(4'd9, 4'd2, 1'b1);
        k    = 0;
        flag = 1'b1;
        while (!err && k < 20) begin
            if (out_valid)
                flag = 1'b0;
            tick();
            k++;
        end
        tick();
        check("ill_err", 32'(err), 1);
        check("ill_dr", 32'({dr_a, dr_b, dr_cin}), 0);
        check("ill_valid", 32'(out_valid), 0);
        check("ill_novalid", 32'(flag), 1);
        check("ill_ready", 32'(in_ready), 0);
        mode = 2'd0;
        do_reset();

        // Reset in the middle of DATA
        accept(4'd3, 4'd4, 1'b0);
        tick();
        tick();
        check("mid_dr_data", 32'(dr_a), 32'(enc4(4'd3)));
        rst_n = 1'b0;
        #1;
        check("mid_dr_null", 32'({dr_a, dr_b, dr_cin}), 0);
        check("mid_valid", 32'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_ready", 32'(in_ready), 1);
        check("mid_err", 32'(err), 0);
        flag = 1'b1;
        repeat (15) begin
            if (out_valid)
                flag = 1'b0;
            tick();
        end
        check("mid_noresult", 32'(flag), 1);
        check("mid_sum", 32'(out_sum), 0);

        run_op(4'd8, 4'd7, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
